// File: rtl/cic_comp_pkg.sv
// Shared state type, default widths, droop-compensation coefficients and the
// round/saturate helper for the CIC compensation FIR.
package cic_comp_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_COEFF_W = 18;
  localparam int DEF_TAPS    = 7;
  localparam int DEF_SHIFT   = 16;
  localparam int DEF_ACC_W   = DEF_DATA_W + DEF_COEFF_W + $clog2(DEF_TAPS);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_e;

  typedef logic signed [DEF_COEFF_W-1:0] coeff_t;

  // Symmetric taps summing to 2^16 so DC passes with unity gain.
  localparam coeff_t COMP_COEFFS [DEF_TAPS] = '{
    -18'sd2048, 18'sd4096, -18'sd12288, 18'sd86016, -18'sd12288, 18'sd4096, -18'sd2048
  };

  function automatic logic signed [DEF_DATA_W-1:0] sat_round(
    input logic signed [DEF_ACC_W-1:0] acc
  );
    logic signed [DEF_ACC_W:0] sum;
    logic signed [DEF_ACC_W:0] r;
    sum = {acc[DEF_ACC_W-1], acc} + ((DEF_ACC_W+1)'(1) << (DEF_SHIFT-1));
    r   = sum >>> DEF_SHIFT;
    if (r > (DEF_ACC_W+1)'(2**(DEF_DATA_W-1)-1)) begin
      return DEF_DATA_W'(2**(DEF_DATA_W-1)-1);
    end else if (r < (DEF_ACC_W+1)'(-(2**(DEF_DATA_W-1)))) begin
      return {1'b1, {(DEF_DATA_W-1){1'b0}}};
    end
    return r[DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Signed multiply-accumulate register with clear/enable, followed by the
// round-half-up arithmetic shift and output saturation.
module cic_comp_mac
  import cic_comp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COEFF_W = DEF_COEFF_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int SHIFT   = DEF_SHIFT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [DATA_W-1:0]  sample_i,
  input  logic [COEFF_W-1:0] coeff_i,
  output logic [DATA_W-1:0]  result_o
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT-1);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(2**(DATA_W-1)-1);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-(2**(DATA_W-1)));

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W:0]    rnd_sum, rnd_shift;

  // Both operands are sign-extended to the product width so the modular
  // product equals the full-precision signed product.
  assign prod = $signed({{COEFF_W{sample_i[DATA_W-1]}}, sample_i})
              * $signed({{DATA_W{coeff_i[COEFF_W-1]}}, coeff_i});

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign rnd_sum   = {acc_q[ACC_W-1], acc_q} + HALF;
  assign rnd_shift = rnd_sum >>> SHIFT;

  always_comb begin
    if (rnd_shift > SAT_HI) begin
      result_o = SAT_HI[DATA_W-1:0];
    end else if (rnd_shift < SAT_LO) begin
      result_o = SAT_LO[DATA_W-1:0];
    end else begin
      result_o = rnd_shift[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: one shared multiplier walks the sample ring
// once per accepted input tick, then rounds, saturates and presents the result.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COEFF_W = DEF_COEFF_W,
  parameter int TAPS    = DEF_TAPS,
  parameter int SHIFT   = DEF_SHIFT,
  parameter logic signed [COEFF_W-1:0] COEFFS [TAPS] = COMP_COEFFS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic [DATA_W-1:0] signal_i,
  output logic              tick_o,
  output logic [DATA_W-1:0] signal_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int PTR_W = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEFF_W + $clog2(TAPS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(TAPS-1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  kidx_q, kidx_d;
  logic [DATA_W-1:0] ring_q [TAPS];
  logic [DATA_W-1:0] signal_q, signal_d;
  logic              overrun_q, overrun_d;
  logic              accept, mac_clr, mac_en;
  logic [DATA_W-1:0] rnd_res;

  // Samples are only taken while idle; any other tick is lost and remembered.
  assign accept = tick_i && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    kidx_d    = kidx_q;
    signal_d  = signal_q;
    overrun_d = overrun_q | (tick_i & ~accept);
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    if (accept) begin
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PTR_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (tick_i) begin
          state_d = MAC;
          rptr_d  = wptr_q;
          kidx_d  = '0;
          mac_clr = 1'b1;
        end
      end
      // The read pointer walks backwards from the newest sample, so tap k
      // always meets the sample from k ticks ago.
      MAC: begin
        mac_en = 1'b1;
        kidx_d = kidx_q + PTR_W'(1);
        rptr_d = (rptr_q == '0) ? LAST : rptr_q - PTR_W'(1);
        if (kidx_q == LAST) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        signal_d = rnd_res;
        state_d  = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      kidx_q    <= '0;
      signal_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      kidx_q    <= kidx_d;
      signal_q  <= signal_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TAPS; i++) begin
        ring_q[i] <= '0;
      end
    end else if (accept) begin
      ring_q[wptr_q] <= signal_i;
    end
  end

  cic_comp_mac #(
    .DATA_W (DATA_W),
    .COEFF_W(COEFF_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (mac_clr),
    .en_i    (mac_en),
    .sample_i(ring_q[rptr_q]),
    .coeff_i (COEFFS[kidx_q]),
    .result_o(rnd_res)
  );

  assign tick_o    = (state_q == OUT);
  assign busy_o    = (state_q == MAC) || (state_q == ROUND);
  assign signal_o  = signal_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed self-checking bench for cic_comp_fir: impulse, DC, saturation,
// overrun, mid-pass reset and minimum-spacing streams.
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               tick_i;
  logic signed [15:0] signal_i;
  logic               tick_o;
  logic signed [15:0] signal_o;
  logic               busy_o;
  logic               overrun_o;

  int checks = 0;
  int errors = 0;
  int hist [DEF_TAPS];

  always #10 clk_i = ~clk_i;

  cic_comp_fir dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tick_i   (tick_i),
    .signal_i (signal_i),
    .tick_o   (tick_o),
    .signal_o (signal_o),
    .busy_o   (busy_o),
    .overrun_o(overrun_o)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEF_TAPS; i++) hist[i] = 0;
  endtask

  // Reference output: direct convolution over the bench's own sample history.
  task automatic modelPush(input int x, output logic signed [15:0] y);
    longint acc;
    logic signed [DEF_ACC_W-1:0] a;
    for (int k = DEF_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    acc = 0;
    for (int k = 0; k < DEF_TAPS; k++) acc += longint'(hist[k]) * longint'(COMP_COEFFS[k]);
    a = acc[DEF_ACC_W-1:0];
    y = sat_round(a);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Drives one tick on the next falling edge and waits (bounded) for tick_o.
  task automatic applyStimulus(input int x, output int lat,
                               output logic signed [15:0] y, output logic busyEarly);
    @(negedge clk_i);
    tick_i    = 1'b1;
    signal_i  = 16'(x);
    lat       = 99;
    busyEarly = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      tick_i = 1'b0;
      if (c == 1) busyEarly = busy_o;
      if (tick_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    y = signal_o;
  endtask

  task automatic runImpulse(input string tag);
    int lat;
    logic signed [15:0] y, m;
    logic b;
    int expv [9];
    expv = '{-31, 63, -187, 1313, -187, 63, -31, 0, 0};
    for (int i = 0; i < 9; i++) begin
      applyStimulus((i == 0) ? 1000 : 0, lat, y, b);
      modelPush((i == 0) ? 1000 : 0, m);
      checkOutput({tag, " out"}, 32'(y), expv[i]);
      if (i == 0) begin
        checkOutput({tag, " latency"}, lat, 9);
        checkOutput({tag, " busy after tick"}, 32'(b), 1);
        checkOutput({tag, " busy in OUT"}, 32'(busy_o), 0);
      end
      waitCycles(240);
      checkOutput({tag, " hold"}, 32'(signal_o), expv[i]);
    end
  endtask

  initial begin
    int lat, seen;
    logic signed [15:0] y, m;
    logic b;

    rst_ni   = 1'b0;
    tick_i   = 1'b0;
    signal_i = '0;
    modelReset();
    waitCycles(3);
    checkOutput("reset signal_o", 32'(signal_o), 0);
    checkOutput("reset tick_o", 32'(tick_o), 0);
    checkOutput("reset busy_o", 32'(busy_o), 0);
    checkOutput("reset overrun_o", 32'(overrun_o), 0);
    rst_ni = 1'b1;
    waitCycles(5);

    $display("[TB] impulse");
    runImpulse("impulse");

    $display("[TB] dc");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(10000, lat, y, b);
      modelPush(10000, m);
      checkOutput("dc latency", lat, 9);
      if (i >= 6) checkOutput("dc settled", 32'(y), 10000);
      else        checkOutput("dc transient", 32'(y), 32'(m));
      waitCycles(240);
    end

    $display("[TB] saturation");
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 32767 : -32767, lat, y, b);
      modelPush((i % 2 == 0) ? 32767 : -32767, m);
      checkOutput("sat model", 32'(y), 32'(m));
      if (i >= 6) checkOutput("sat clamp", 32'(y), (i % 2 == 0) ? -32768 : 32767);
      waitCycles(240);
    end

    $display("[TB] overrun");
    @(negedge clk_i);
    tick_i   = 1'b1;
    signal_i = 16'(5000);
    modelPush(5000, m);
    @(negedge clk_i);
    tick_i = 1'b0;
    waitCycles(3);
    tick_i   = 1'b1;
    signal_i = 16'(7777);
    @(negedge clk_i);
    tick_i = 1'b0;
    checkOutput("overrun set", 32'(overrun_o), 1);
    lat = 99;
    for (int c = 6; c <= 30; c++) begin
      @(negedge clk_i);
      if (tick_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    checkOutput("overrun pass latency", lat, 9);
    checkOutput("overrun pass out", 32'(signal_o), 32'(m));
    waitCycles(2);
    applyStimulus(3000, lat, y, b);
    modelPush(3000, m);
    checkOutput("after overrun out", 32'(y), 32'(m));
    checkOutput("after overrun latency", lat, 9);
    checkOutput("overrun sticky", 32'(overrun_o), 1);
    waitCycles(20);

    $display("[TB] reset mid-pass");
    @(negedge clk_i);
    tick_i   = 1'b1;
    signal_i = 16'(1000);
    @(negedge clk_i);
    tick_i = 1'b0;
    waitCycles(2);
    rst_ni = 1'b0;
    #1;
    checkOutput("abort signal_o", 32'(signal_o), 0);
    checkOutput("abort overrun_o", 32'(overrun_o), 0);
    checkOutput("abort busy_o", 32'(busy_o), 0);
    waitCycles(2);
    rst_ni = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (tick_o !== 1'b0) seen++;
    end
    checkOutput("abort no tick_o", seen, 0);
    modelReset();
    runImpulse("impulse2");

    $display("[TB] back-to-back");
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i * 9973) % 50000 - 25000, lat, y, b);
      modelPush((i * 9973) % 50000 - 25000, m);
      checkOutput("b2b out", 32'(y), 32'(m));
      checkOutput("b2b latency", lat, 9);
    end
    checkOutput("b2b no overrun", 32'(overrun_o), 0);

    $display("[TB] tick during OUT");
    @(negedge clk_i);
    tick_i   = 1'b1;
    signal_i = 16'(111);
    modelPush(111, m);
    lat = 99;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      tick_i = 1'b0;
      if (tick_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    tick_i   = 1'b1;
    signal_i = 16'(222);
    @(negedge clk_i);
    tick_i = 1'b0;
    checkOutput("out-cycle latency", lat, 9);
    checkOutput("out-cycle pass out", 32'(signal_o), 32'(m));
    checkOutput("out-cycle tick dropped", 32'(overrun_o), 1);
    waitCycles(2);
    applyStimulus(333, lat, y, b);
    modelPush(333, m);
    checkOutput("after out-cycle out", 32'(y), 32'(m));
    waitCycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
